// File: rtl/jam_pkg.sv
// jam_pkg: shared FSM state type, size limit and elaboration-time helpers for jam_search_param
//   No ports. Provides:
//     state_t  - controller states IDLE/EVAL/UPD/DONE
//     MAX_N    - largest supported worker/job count
//     fact     - n! for sizing the match counter
//     idx_w    - address width for n workers (minimum 1)
//     bits_for - bits needed to hold the value v
package jam_pkg;
   typedef enum logic [1:0] {IDLE, EVAL, UPD, DONE} state_t;
   localparam int MAX_N = 8;
   function automatic int fact(input int n);
      int f;
      f = 1;
      for (int i = 2; i <= n; i++) f *= i;
      return f;
   endfunction
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
   function automatic int bits_for(input int v);
      return (v <= 1) ? 1 : $clog2(v + 1);
   endfunction
endpackage

// File: rtl/jam_search_param_if.sv
// jam_search_param_if: run handshake, cost-ROM address/data and result bus of jam_search_param
//   START      run request (slave -> master)
//   W, J       worker/job address to the cost ROM (master -> slave)
//   Cost       registered ROM data for the previous cycle's W/J (slave -> master)
//   BUSY       run in progress (master -> slave)
//   Valid      one-cycle result strobe (master -> slave)
//   MinCost    minimum total cost of the last completed run (master -> slave)
//   MatchCount saturating count of assignments reaching MinCost (master -> slave)
interface jam_search_param_if
   import jam_pkg::*;
#(
   parameter int N       = 8,
   parameter int COST_W  = 7,
   parameter int MATCH_W = 4,
   parameter int IDX_W   = idx_w(N),
   parameter int SUM_W   = COST_W + $clog2(N)
);
   logic               START;
   logic [IDX_W-1:0]   W;
   logic [IDX_W-1:0]   J;
   logic [COST_W-1:0]  Cost;
   logic               BUSY;
   logic               Valid;
   logic [SUM_W-1:0]   MinCost;
   logic [MATCH_W-1:0] MatchCount;
   modport master (input START, Cost, output W, J, BUSY, Valid, MinCost, MatchCount);
   modport slave  (output START, Cost, input W, J, BUSY, Valid, MinCost, MatchCount);
endinterface

// File: rtl/jam_next_perm.sv
// jam_next_perm: combinational lexicographic successor of a permutation
//   p     in  current permutation, element k in slice [k]
//   p_nxt out next permutation in lexicographic order (don't-care when last)
//   last  out p is strictly descending, i.e. it has no successor
module jam_next_perm #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0][IDX_W-1:0] p,
   output logic [N-1:0][IDX_W-1:0] p_nxt,
   output logic                    last
);
   logic [IDX_W-1:0]          piv;
   logic [IDX_W-1:0]          sw;
   logic [N-1:0][IDX_W-1:0]   t;
   always_comb begin
      piv  = '0;
      last = 1'b1;
      for (int i = 0; i < N - 1; i++)
         if (p[i] < p[i+1]) begin
            piv  = IDX_W'(i);
            last = 1'b0;
         end
      sw = piv;
      for (int j = 0; j < N; j++)
         if (IDX_W'(j) > piv && p[j] > p[piv]) sw = IDX_W'(j);
      t      = p;
      t[piv] = p[sw];
      t[sw]  = p[piv];
      p_nxt  = t;
      // the suffix after the pivot is descending; reversing it makes it the smallest tail
      for (int j = 0; j < N; j++)
         for (int m = 0; m < N; m++)
            if (j > int'(piv) && m == N + int'(piv) - j) p_nxt[j] = t[m];
   end
endmodule

// File: rtl/jam_search_param.sv
// jam_search_param: exhaustive N-worker/N-job assignment search with min-cost and match count
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-low reset
//   bus  master side of jam_search_param_if (START, W, J, Cost, BUSY, Valid, MinCost, MatchCount)
//   Optional JAM_PRUNE_EN: abandon a permutation once its partial sum exceeds the best so far.
module jam_search_param
   import jam_pkg::*;
#(
   parameter int N       = 8,
   parameter int COST_W  = 7,
   parameter int MATCH_W = 4,
   parameter int IDX_W   = idx_w(N),
   parameter int SUM_W   = COST_W + $clog2(N)
) (
   input logic               CLK,
   input logic               RST,
   jam_search_param_if.master bus
);
   localparam int K_W = $clog2(N + 1);

   if (N < 2 || N > MAX_N) begin : g_bad_n
      $error("jam_search_param: N must be 2..%0d", MAX_N);
   end
   if (SUM_W < bits_for(N * (2 ** COST_W - 1))) begin : g_bad_sum
      $error("jam_search_param: SUM_W too narrow for N*max cost");
   end
   if (MATCH_W < 1 || MATCH_W > bits_for(fact(N))) begin : g_bad_match
      $error("jam_search_param: MATCH_W must be 1..bits(N!)");
   end
   if (IDX_W < idx_w(N)) begin : g_bad_idx
      $error("jam_search_param: IDX_W too narrow for N");
   end

   state_t                  state, state_nxt;
   logic [K_W-1:0]          k;
   logic [N-1:0][IDX_W-1:0] p, p_nxt;
   logic                    last;
   logic [SUM_W-1:0]        acc, acc_add, min_r, min_nxt;
   logic [MATCH_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]        w_idx;
   logic                    prune_now, pruned;

   jam_next_perm #(.N(N), .IDX_W(IDX_W)) u_next (.p(p), .p_nxt(p_nxt), .last(last));

   // at k==N the address holds its last value while the final Cost is accumulated
   assign w_idx   = (k < K_W'(N)) ? IDX_W'(k) : IDX_W'(N - 1);
   assign bus.W   = (state == EVAL) ? w_idx : '0;
   assign bus.J   = (state == EVAL) ? p[w_idx] : '0;
   assign acc_add = acc + SUM_W'(bus.Cost);

`ifdef JAM_PRUNE_EN
   // strictly greater only: equal partial sums may still tie and must be counted
   assign prune_now = (state == EVAL) && (k != '0) && (acc_add > min_r);
`else
   assign prune_now = 1'b0;
`endif

   assign min_nxt = (!pruned && acc < min_r) ? acc : min_r;
   assign cnt_nxt = pruned ? cnt :
                    (acc < min_r) ? MATCH_W'(1) :
                    (acc == min_r && !(&cnt)) ? cnt + 1'b1 : cnt;

   always_ff @(posedge CLK or negedge RST)
      if (!RST) state <= IDLE;
      else      state <= state_nxt;

   always_comb begin
      state_nxt = state;
      bus.BUSY  = 1'b0;
      bus.Valid = 1'b0;
      case (state)
         IDLE: state_nxt = bus.START ? EVAL : IDLE;
         EVAL: begin
            bus.BUSY  = 1'b1;
            state_nxt = (prune_now || k == K_W'(N)) ? UPD : EVAL;
         end
         UPD: begin
            bus.BUSY  = 1'b1;
            state_nxt = last ? DONE : EVAL;
         end
         DONE: begin
            bus.Valid = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         k              <= '0;
         acc            <= '0;
         min_r          <= '0;
         cnt            <= '0;
         pruned         <= 1'b0;
         bus.MinCost    <= '0;
         bus.MatchCount <= '0;
         for (int i = 0; i < N; i++) p[i] <= IDX_W'(i);
      end else begin
         case (state)
            IDLE:
               if (bus.START) begin
                  k      <= '0;
                  acc    <= '0;
                  min_r  <= '1;
                  cnt    <= '0;
                  pruned <= 1'b0;
                  for (int i = 0; i < N; i++) p[i] <= IDX_W'(i);
               end
            EVAL: begin
               k <= k + 1'b1;
               if (k != '0) acc <= acc_add;
               if (prune_now) pruned <= 1'b1;
            end
            UPD: begin
               k      <= '0;
               acc    <= '0;
               pruned <= 1'b0;
               min_r  <= min_nxt;
               cnt    <= cnt_nxt;
               if (last) begin
                  bus.MinCost    <= min_nxt;
                  bus.MatchCount <= cnt_nxt;
               end else p <= p_nxt;
            end
            default: ;
         endcase
      end
endmodule

// File: doc/jam_search_param.md
Name: jam_search_param

Overview:
- Parametrised successor to the team's fixed 8x8 job-assignment engine.
- Exhaustively enumerates all N! worker-to-job assignments in lexicographic order.
- Fetches each cost from an external cost ROM over a W/J address interface, then reports the minimum total cost and how many assignments reach it.
- Adds a START/BUSY handshake so the block can be re-run without reset, plus a saturating, width-configurable match counter.

Parameters:
- N, 8, number of workers = number of jobs; legal range 2..8
- COST_W, 7, width of one ROM cost entry
- MATCH_W, 4, width of MatchCount; saturates at all-ones
- IDX_W, $clog2(N) (minimum 1), width of W and J
- SUM_W, COST_W+$clog2(N), width of MinCost and the accumulator

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  run request; sampled only in IDLE
- W  out  IDX_W  worker address to cost ROM
- J  out  IDX_W  job address to cost ROM
- Cost  in  COST_W  ROM data for the W/J driven in the previous cycle
- BUSY  out  1  high from the cycle after START is accepted until DONE
- Valid  out  1  one-cycle result strobe
- MinCost  out  SUM_W  minimum total cost of the last completed run
- MatchCount  out  MATCH_W  number of permutations achieving MinCost, saturating

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; W=J=0, BUSY=0, Valid=0, MinCost=0, MatchCount=0; permutation register p[k]=k. Reset mid-run aborts with no Valid.
- ROM timing: address driven in cycle t; Cost is valid and sampled at the rising edge ending cycle t+1.
- IDLE: W=J=0. On START=1: p:=identity, acc:=0, min:=all-ones, cnt:=0, go to EVAL.
- EVAL: counter k runs 0..N, so the state lasts N+1 cycles.
  - For k<N: drive W=k, J=p[k].
  - For k>=1: acc += Cost.
  - At k=N: W/J hold their last value, and acc holds the full sum at the end of the cycle.
- UPD (1 cycle):
  - If acc<min: min:=acc, cnt:=1.
  - If acc==min: cnt:=cnt+1, saturating at 2^MATCH_W-1.
  - If p is strictly descending (no pivot), go to DONE.
  - Otherwise p:=next_perm(p), acc:=0, go to EVAL.
  - next_perm: pivot i = largest index with p[i]<p[i+1]; swap p[i] with the largest-index p[j]>p[i], j>i; reverse p[i+1..N-1].
- DONE (1 cycle): MinCost:=min, MatchCount:=cnt (registered at DONE entry, so visible the same cycle); Valid=1; BUSY=0; next state IDLE.
- Latency: with START accepted at edge e0, Valid is high exactly N!*(N+2)+1 cycles after e0 (without JAM_PRUNE_EN).
- MinCost/MatchCount hold until the next DONE; START does not clear them.
- START while BUSY or in DONE is ignored. START high in the IDLE cycle after DONE starts a new run.
- Arithmetic is unsigned. acc cannot overflow: N*(2^COST_W-1) < 2^SUM_W.

Optional Feature:
- Macro: JAM_PRUNE_EN.
- Defined: in EVAL, if the running acc (after an add) is strictly greater than min, stop issuing addresses. Go directly to UPD, which skips the compare and only advances the permutation. Equal partial sums are never pruned, so MatchCount is preserved. Results are bit-identical to the unpruned run; only cycle count shrinks.
- Undefined: every permutation takes exactly N+2 cycles.

Decomposition:
- Shared package jam_pkg:
  - state enum {IDLE, EVAL, UPD, DONE}
  - max-N constant 8
  - factorial/width helper functions used to check MATCH_W and SUM_W in elaboration assertions
- One sub-module: jam_next_perm. Purely combinational; input p array; outputs next p and a last flag. Reusable by the bench's reference model.

Test Plan:
- N=8, all costs 5, MATCH_W=4 -> MinCost=40, MatchCount=15 (saturated); with MATCH_W=16 -> MatchCount=40320; Valid 403201 cycles after START.
- N=4, cost 0 on diagonal, 1 elsewhere -> MinCost=0, MatchCount=1; Valid 145 cycles after START; W/J sequence of the first EVAL is (0,0),(1,1),(2,2),(3,3).
- N=8, the team's three standard cost_rom patterns -> MinCost/MatchCount equal the golden min_cost/match_count lines.
- RST pulsed low mid-EVAL, then START -> all outputs 0 immediately after reset, no Valid during abort; rerun result correct.
- START held high for two runs -> second run begins in the IDLE cycle after the first DONE; second Valid has identical values; START during BUSY has no effect.
- JAM_PRUNE_EN defined, standard pattern 1 -> same MinCost/MatchCount as undefined build; Valid cycle count strictly smaller.
